// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - registered arithmetic stage: single-cycle add/sub/mul, restoring divider for div/mod
module arith_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_flag
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  b_reg;
  logic [CW-1:0]     cnt;
  logic              is_mod;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]    rem_sh;
  logic              rem_ge;
  logic [WIDTH-1:0]  rem_nx;
  logic [WIDTH-1:0]  dvd_nx;

  always_comb begin
    sum  = {1'b0, in_a} + {1'b0, in_b};
    diff = {1'b0, in_a} - {1'b0, in_b};
    prod = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
  end

  // Dividend shifts out MSB-first while quotient bits fill in from the LSB.
  // The remainder stays below b, so the shifted value fits in WIDTH+1 bits.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    rem_ge = (rem_sh >= {1'b0, b_reg});
    rem_nx = rem_ge ? WIDTH'(rem_sh - {1'b0, b_reg}) : rem_sh[WIDTH-1:0];
    dvd_nx = {dvd[WIDTH-2:0], rem_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flag   <= 1'b0;
      rem        <= '0;
      dvd        <= '0;
      b_reg      <= '0;
      cnt        <= '0;
      is_mod     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            case (in_op)
              OP_ADD: begin
                out_result <= sum[WIDTH-1:0];
                out_flag   <= sum[WIDTH];
              end
              OP_SUB: begin
                out_result <= diff[WIDTH-1:0];
                out_flag   <= (in_a < in_b);
              end
              OP_MUL: begin
                out_result <= prod[WIDTH-1:0];
                out_flag   <= |prod[2*WIDTH-1:WIDTH];
              end
              OP_DIV, OP_MOD: begin
                if (in_b == '0) begin
                  out_result <= (in_op == OP_DIV) ? '1 : in_a;
                  out_flag   <= 1'b1;
                end else begin
                  state     <= S_DIV;
                  out_valid <= 1'b0;
                  rem       <= '0;
                  dvd       <= in_a;
                  b_reg     <= in_b;
                  cnt       <= CW'(WIDTH);
                  is_mod    <= (in_op == OP_MOD);
                end
              end
              default: begin
                out_result <= '0;
                out_flag   <= 1'b1;
              end
            endcase
          end
        end
        S_DIV: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            out_result <= is_mod ? rem_nx : dvd_nx;
            out_flag   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb/tb_arith_seq_unit.sv - directed self-checking bench for arith_seq_unit
module tb_arith_seq_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_flag;

  int checks = 0;
  int errors = 0;

  arith_seq_unit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one request, scrambles operands after accept, measures latency,
  // checks result/flag and (if out_ready is high) the return to IDLE.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int exp_res, input int exp_flag,
                       input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_ready_before"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_op    = 3'd0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, int'(out_result), exp_res);
    check({tag, "_flag"}, int'(out_flag), exp_flag);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_idle_valid"}, int'(out_valid), 0);
      check({tag, "_idle_ready"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_result", int'(out_result), 0);
    check("rst_flag", int'(out_flag), 0);
    rst_n = 1'b1;

    do_op("add_3_4",  3'd0, 4'd3,  4'd4, 7,  0, 1);
    do_op("add_15_1", 3'd0, 4'd15, 4'd1, 0,  1, 1);
    do_op("sub_3_4",  3'd1, 4'd3,  4'd4, 15, 1, 1);
    do_op("sub_4_3",  3'd1, 4'd4,  4'd3, 1,  0, 1);
    do_op("mul_3_4",  3'd2, 4'd3,  4'd4, 12, 0, 1);
    do_op("mul_5_4",  3'd2, 4'd5,  4'd4, 4,  1, 1);
    do_op("div_3_2",  3'd3, 4'd3,  4'd2, 1,  0, 5);
    do_op("mod_3_2",  3'd4, 4'd3,  4'd2, 1,  0, 5);
    do_op("div_15_1", 3'd3, 4'd15, 4'd1, 15, 0, 5);
    do_op("mod_2_3",  3'd4, 4'd2,  4'd3, 2,  0, 5);
    do_op("div_13_3", 3'd3, 4'd13, 4'd3, 4,  0, 5);
    do_op("mod_13_3", 3'd4, 4'd13, 4'd3, 1,  0, 5);
    do_op("div_3_0",  3'd3, 4'd3,  4'd0, 15, 1, 1);
    do_op("mod_3_0",  3'd4, 4'd3,  4'd0, 3,  1, 1);
    do_op("op6",      3'd6, 4'd9,  4'd2, 0,  1, 1);
    do_op("op7",      3'd7, 4'd1,  4'd1, 0,  1, 1);

    // Backpressure: result must hold while upstream keeps poking.
    out_ready = 1'b0;
    do_op("bp_mul_5_4", 3'd2, 4'd5, 4'd4, 4, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a     = 4'(i);
      in_op    = 3'd0;
      @(posedge clk);
      #1;
      check("bp_hold_result", int'(out_result), 4);
      check("bp_hold_flag", int'(out_flag), 1);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd3;
    in_a     = 4'd15;
    in_b     = 4'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rdiv_busy_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rdiv_rst_valid", int'(out_valid), 0);
    check("rdiv_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("rdiv_no_stray", int'(out_valid), 0);
    end

    do_op("post_rst_add", 3'd0, 4'd9, 4'd9, 2, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
